payload_engine_ctrl: RTL and testbench

- Per-packet sequencer for a bank of NUM_ENG payload regex engines that share one character decoder.
- Takes payload bytes over a valid/ready stream and clears the engines with an eng_sod pulse at packet start.
- Drives dec_data/dec_valid/eng_en per accepted byte, holds eng_en through the pipeline drain after the last byte, then captures the engines' sticky match vector.
- Presents the captured vector, packet length and counters to downstream logic through a valid/ready result handshake.

---
 rtl/payload_engine_ctrl.sv | 154 +++++++++++++++
 tb/tb_payload_engine_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/payload_engine_ctrl.sv
// -----------------------------------------------------------------------------
// payload_engine_ctrl
//
// Per-packet sequencer for a bank of NUM_ENG payload regex engines that share
// one character decoder. For every packet it:
//   1. clears all engines with a one-cycle eng_sod pulse,
//   2. forwards each accepted payload byte to the decoder (dec_data/dec_valid)
//      and advances the engines with eng_en only on cycles that carry a byte,
//   3. keeps eng_en high with the decoder gated off so the engine pipeline
//      drains after the last byte, then captures the sticky match vector,
//   4. offers the captured vector, byte count and running counters on a
//      result handshake.
//
// Handshakes (both streams): a transfer happens on a rising clk edge where
// valid && ready are both high. The sender holds its payload stable while
// valid is high and ready is low. Ready may be high without valid, and that
// has no effect.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   s_data/s_valid/s_last/s_ready   payload byte stream in
//   dec_data, dec_valid  registered byte and gate to the character decoder
//   eng_sod              engine clear (high throughout reset as well)
//   eng_en               engine clock enable
//   eng_match            sticky engine match bits
//   res_match, res_any, res_len, res_valid, res_ready   result handshake
//   pkt_cnt, hit_cnt     completed packets / completed packets with a match
// -----------------------------------------------------------------------------
module payload_engine_ctrl #(
  parameter int NUM_ENG  = 64,
  parameter int PIPE_LAT = 2,
  parameter int LEN_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [7:0]         dec_data,
  output logic               dec_valid,
  output logic               eng_sod,
  output logic               eng_en,
  input  logic [NUM_ENG-1:0] eng_match,
  output logic [NUM_ENG-1:0] res_match,
  output logic               res_any,
  output logic [LEN_W-1:0]   res_len,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        pkt_cnt,
  output logic [31:0]        hit_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    REPORT = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(PIPE_LAT + 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] drain_cnt;
  logic             sod_q;
  logic             beat;
  logic             drain_done;
  logic             res_fire;

  // s_ready is high exactly in STREAM, so a beat can only happen there.
  assign beat       = s_valid && s_ready;
  assign drain_done = (state == DRAIN) && (drain_cnt == CNT_W'(1));
  assign res_fire   = (state == REPORT) && res_valid && res_ready;

  // Engines must stay cleared for the whole reset, not just after it.
  assign eng_sod = rst | sod_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (s_valid) state_next = CLEAR;   // byte waits for STREAM
      CLEAR:   state_next = STREAM;
      STREAM:  if (beat && s_last) state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = REPORT;
      REPORT:  if (res_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and registered outputs. Control outputs are decoded from
  // state_next so they line up with the state they belong to.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sod_q     <= 1'b0;
      s_ready   <= 1'b0;
      dec_data  <= 8'd0;
      dec_valid <= 1'b0;
      eng_en    <= 1'b0;
      drain_cnt <= '0;
      res_match <= '0;
      res_any   <= 1'b0;
      res_len   <= '0;
      res_valid <= 1'b0;
      pkt_cnt   <= 32'd0;
      hit_cnt   <= 32'd0;
    end else begin
      state     <= state_next;
      sod_q     <= (state_next == CLEAR);
      s_ready   <= (state_next == STREAM);
      res_valid <= (state_next == REPORT);

      // The decoder only sees a live byte on the cycle after its beat. In
      // DRAIN the decoder is gated off, so the engines shift all-zero classes.
      dec_valid <= beat;
      eng_en    <= beat || (state_next == DRAIN);
      if (beat) begin
        dec_data <= s_data;
      end

      if (state == CLEAR) begin
        res_len <= '0;
      end else if (beat && (res_len != {LEN_W{1'b1}})) begin
        res_len <= res_len + LEN_W'(1);
      end

      // The count is loaded with the last beat; the first DRAIN cycle is the
      // one carrying that byte, and the vector is sampled as the count hits 1.
      if (beat && s_last) begin
        drain_cnt <= CNT_W'(PIPE_LAT);
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt - CNT_W'(1);
      end

      if (drain_done) begin
        res_match <= eng_match;
        res_any   <= |eng_match;
      end

      if (res_fire) begin
        pkt_cnt <= pkt_cnt + 32'd1;
        hit_cnt <= hit_cnt + {31'd0, res_any};
      end
    end
  end

endmodule

// File: tb/tb_payload_engine_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for payload_engine_ctrl. A small behavioural engine bank sits on the
// decoder/engine outputs: engine 0 flags "selection", engine 1 flags ".view.s"
// (which spans the stall point of the stalled packet). Both clear on eng_sod
// and advance only on eng_en, with one cycle of latency.
// -----------------------------------------------------------------------------
module tb_payload_engine_ctrl;

  localparam int NUM_ENG  = 64;
  localparam int PIPE_LAT = 2;
  localparam int LEN_W    = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]         s_data;
  logic               s_valid;
  logic               s_last;
  logic               s_ready;
  logic [7:0]         dec_data;
  logic               dec_valid;
  logic               eng_sod;
  logic               eng_en;
  logic [NUM_ENG-1:0] eng_match;
  logic [NUM_ENG-1:0] res_match;
  logic               res_any;
  logic [LEN_W-1:0]   res_len;
  logic               res_valid;
  logic               res_ready;
  logic [31:0]        pkt_cnt;
  logic [31:0]        hit_cnt;

  payload_engine_ctrl #(
    .NUM_ENG  (NUM_ENG),
    .PIPE_LAT (PIPE_LAT),
    .LEN_W    (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .dec_data  (dec_data),
    .dec_valid (dec_valid),
    .eng_sod   (eng_sod),
    .eng_en    (eng_en),
    .eng_match (eng_match),
    .res_match (res_match),
    .res_any   (res_any),
    .res_len   (res_len),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .pkt_cnt   (pkt_cnt),
    .hit_cnt   (hit_cnt)
  );

  // ---------------------------------------------------------------------------
  // Engine bank model
  // ---------------------------------------------------------------------------
  localparam logic [71:0] PAT0 = "selection";
  localparam logic [55:0] PAT1 = ".view.s";

  logic [71:0] hist;
  logic [71:0] win;
  always_comb win = {hist[63:0], (dec_valid ? dec_data : 8'h00)};

  always @(posedge clk) begin
    if (eng_sod) begin
      hist      <= '0;
      eng_match <= '0;
    end else if (eng_en) begin
      hist <= win;
      if (win == PAT0)       eng_match[0] <= 1'b1;
      if (win[55:0] == PAT1) eng_match[1] <= 1'b1;
    end
  end

  // eng_sod cycles outside reset, and the count seen when eng_en last rose.
  int   sod_cnt     = 0;
  int   sod_at_rise = 0;
  logic en_prev     = 1'b0;
  always @(negedge clk) begin
    if (eng_sod && !rst) sod_cnt++;
    if (eng_en && !en_prev) sod_at_rise = sod_cnt;
    en_prev = eng_en;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  int last_beat     = 0;
  int first_beat    = 0;
  int rv_cyc        = 0;
  int hs_cyc        = 0;
  int stall_en_hits = 0;

  task automatic push_byte(input logic [7:0] b, input logic last);
    int n;
    n       = 0;
    s_data  = b;
    s_valid = 1'b1;
    s_last  = last;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      check("beat_timeout", 64'd0, 64'd1);
    end else begin
      @(posedge clk);
      #1;
      last_beat = cyc;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Sends a string; after byte number stall_after, holds s_valid low for
  // stall_len cycles and counts cycles where eng_en is seen high.
  task automatic send_str(input string s, input int stall_after, input int stall_len);
    stall_en_hits = 0;
    for (int i = 0; i < s.len(); i++) begin
      push_byte(s[i], (i == s.len() - 1));
      if (i == 0) first_beat = last_beat;
      if (i + 1 == stall_after) begin
        for (int k = 0; k < stall_len; k++) begin
          @(posedge clk);
          #1;
          if (eng_en) stall_en_hits++;
        end
      end
    end
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    rv_cyc = cyc;
    check("res_valid_seen", 64'(res_valid), 64'd1);
  endtask

  task automatic check_result(input string tag, input int len, input logic any);
    logic [63:0] exp;
    exp = exp_q.pop_front();
    check({tag, "_match"}, 64'(res_match), exp);
    check({tag, "_any"},   64'(res_any),   64'(any));
    check({tag, "_len"},   64'(res_len),   64'(len));
  endtask

  // res_ready must already be high.
  task automatic handshake();
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    check("res_valid_drop", 64'(res_valid), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  int                 snap;
  int                 bad;
  logic [NUM_ENG-1:0] held_match;
  logic [LEN_W-1:0]   held_len;

  initial begin
    s_data    = 8'd0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    res_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_eng_sod",   64'(eng_sod),   64'd1);
    check("rst_s_ready",   64'(s_ready),   64'd0);
    check("rst_dec_data",  64'(dec_data),  64'd0);
    check("rst_dec_valid", 64'(dec_valid), 64'd0);
    check("rst_eng_en",    64'(eng_en),    64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_match", 64'(res_match), 64'd0);
    check("rst_res_len",   64'(res_len),   64'd0);
    check("rst_pkt_cnt",   64'(pkt_cnt),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_eng_sod", 64'(eng_sod), 64'd0);
    @(posedge clk);
    #1;

    // Packet 1: matching, res_ready already high
    res_ready = 1'b1;
    snap      = sod_cnt;
    exp_q.push_back(64'h3);
    send_str(".view.selection", 0, 0);
    wait_result();
    check("p1_latency", 64'(rv_cyc - last_beat), 64'd2);
    check("p1_sod_pulses", 64'(sod_at_rise - snap), 64'd1);
    check_result("p1", 15, 1'b1);
    handshake();
    check("p1_pkt_cnt", 64'(pkt_cnt), 64'd1);
    check("p1_hit_cnt", 64'(hit_cnt), 64'd1);

    // Packet 2: same bytes, 5-cycle stall after byte 6
    exp_q.push_back(64'h3);
    send_str(".view.selection", 6, 5);
    check("p2_stall_eng_en", 64'(stall_en_hits), 64'd0);
    wait_result();
    check_result("p2", 15, 1'b1);
    handshake();
    check("p2_pkt_cnt", 64'(pkt_cnt), 64'd2);
    check("p2_hit_cnt", 64'(hit_cnt), 64'd2);

    // Packet 3: single non-matching byte
    exp_q.push_back(64'h0);
    send_str("x", 0, 0);
    wait_result();
    check("p3_latency", 64'(rv_cyc - last_beat), 64'd2);
    check_result("p3", 1, 1'b0);
    handshake();
    check("p3_pkt_cnt", 64'(pkt_cnt), 64'd3);
    check("p3_hit_cnt", 64'(hit_cnt), 64'd2);

    // Packets 4/5: result held pending while the next packet waits
    res_ready = 1'b0;
    exp_q.push_back(64'h3);
    send_str(".view.selection", 0, 0);
    wait_result();
    check_result("p4", 15, 1'b1);
    held_match = res_match;
    held_len   = res_len;
    s_data     = "a";
    s_valid    = 1'b1;
    bad        = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (s_ready || !res_valid || res_match !== held_match || res_len !== held_len) bad++;
    end
    check("p4_pending_hold", 64'(bad), 64'd0);
    check("p4_pending_cnt", 64'(pkt_cnt), 64'd3);
    res_ready = 1'b1;
    handshake();
    snap = sod_cnt;
    check("p4_pkt_cnt", 64'(pkt_cnt), 64'd4);
    check("p4_hit_cnt", 64'(hit_cnt), 64'd3);
    exp_q.push_back(64'h0);
    send_str("abc", 0, 0);
    check("p5_gap", 64'(first_beat - hs_cyc), 64'd3);
    wait_result();
    check("p5_sod_pulses", 64'(sod_at_rise - snap), 64'd1);
    check_result("p5", 3, 1'b0);
    handshake();
    check("p5_pkt_cnt", 64'(pkt_cnt), 64'd5);
    check("p5_hit_cnt", 64'(hit_cnt), 64'd3);

    // Packet 6: 300 bytes saturate an 8-bit length
    exp_q.push_back(64'h0);
    for (int i = 0; i < 300; i++) push_byte("z", (i == 299));
    wait_result();
    check_result("p6", 255, 1'b0);
    handshake();
    check("p6_pkt_cnt", 64'(pkt_cnt), 64'd6);

    // Reset during byte 4, then a normal packet
    push_byte("a", 1'b0);
    push_byte("b", 1'b0);
    push_byte("c", 1'b0);
    s_data  = "d";
    s_valid = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_eng_sod",   64'(eng_sod),   64'd1);
    check("mid_rst_s_ready",   64'(s_ready),   64'd0);
    check("mid_rst_eng_en",    64'(eng_en),    64'd0);
    check("mid_rst_dec_valid", 64'(dec_valid), 64'd0);
    check("mid_rst_res_len",   64'(res_len),   64'd0);
    check("mid_rst_pkt_cnt",   64'(pkt_cnt),   64'd0);
    check("mid_rst_hit_cnt",   64'(hit_cnt),   64'd0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (res_valid) bad++;
    end
    check("mid_rst_no_result", 64'(bad), 64'd0);
    @(posedge clk);
    #1;
    exp_q.push_back(64'h2);
    send_str(".view.s", 0, 0);
    wait_result();
    check_result("p7", 7, 1'b1);
    handshake();
    check("p7_pkt_cnt", 64'(pkt_cnt), 64'd1);
    check("p7_hit_cnt", 64'(hit_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
